// File: rtl/figan_pkg.sv
// figan_pkg: fixed-point constants and helpers shared by the discriminator and
// generator layers (conv2d, transposed conv, leaky-ReLU).
//   DATA_WIDTH / FRAC_BITS : default Q format (Q7.8)
//   ACC_WIDTH              : width of a 16-tap MAC sum with headroom
//   SAT_MAX / SAT_MIN      : saturation bounds of a DATA_WIDTH signed word
//   sat_shift(acc)         : arithmetic shift by FRAC_BITS, then saturate
package figan_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH + 4;

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Shift right toward -inf, then clamp into the DATA_WIDTH signed range.
  function automatic logic signed [DATA_WIDTH-1:0] sat_shift(
    input logic signed [ACC_WIDTH-1:0] acc
  );
    logic signed [ACC_WIDTH-1:0] shifted_s;
    logic signed [ACC_WIDTH-1:0] max_s;
    logic signed [ACC_WIDTH-1:0] min_s;
    shifted_s = acc >>> FRAC_BITS;
    max_s     = {{(ACC_WIDTH-DATA_WIDTH){SAT_MAX[DATA_WIDTH-1]}}, SAT_MAX};
    min_s     = {{(ACC_WIDTH-DATA_WIDTH){SAT_MIN[DATA_WIDTH-1]}}, SAT_MIN};
    if (shifted_s > max_s) begin
      return SAT_MAX;
    end else if (shifted_s < min_s) begin
      return SAT_MIN;
    end else begin
      return shifted_s[DATA_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/conv2d_4x4_s2_layer_if.sv
// conv2d_4x4_s2_layer_if: pixel-in / result-out streaming handshake bundle.
//   valid_in, data_in, ready_out : upstream pixel channel
//   valid_out, data_out, last_out, ready_in : downstream result channel
//   modport slave  : the convolution layer
//   modport master : the producer/consumer around it
interface conv2d_4x4_s2_layer_if #(
  parameter int DATA_WIDTH = 16
);

  logic                  valid_in;
  logic                  ready_out;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_out;
  logic                  ready_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  last_out;

  modport master (
    output valid_in, data_in, ready_in,
    input  ready_out, valid_out, data_out, last_out
  );

  modport slave (
    input  valid_in, data_in, ready_in,
    output ready_out, valid_out, data_out, last_out
  );

endinterface

// File: rtl/conv2d_4x4_s2_layer_line_buffer_rows.sv
// line_buffer_rows: three column-indexed row buffers plus a 4x4 window.
//   clk      : rising-edge clock
//   en       : accept strobe; buffers and window advance only when high
//   col      : column of the pixel being accepted
//   pix      : pixel being accepted
//   win_flat : window that includes the pixel being accepted this cycle;
//              word k = 4*kr + kc, (3,3) = pix, (0,0) = pixel at (row-3, col-3)
// Contents are intentionally not reset; downstream gating ignores stale data.
module line_buffer_rows #(
  parameter int IN_WIDTH   = 23,
  parameter int DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic [$clog2(IN_WIDTH)-1:0] col,
  input  logic [DATA_WIDTH-1:0]      pix,
  output logic [16*DATA_WIDTH-1:0]   win_flat
);

  // rb_r[0] holds the previous row, rb_r[2] the row three above.
  logic [DATA_WIDTH-1:0] rb_r       [3][IN_WIDTH];
  logic [DATA_WIDTH-1:0] win_r      [4][4];
  logic [DATA_WIDTH-1:0] win_next_s [4][4];

  // Next window: shift each row left and append this column's vertical slice.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_next_s[r][c] = win_r[r][c+1];
      end
    end
    win_next_s[3][3] = pix;
    win_next_s[2][3] = rb_r[0][col];
    win_next_s[1][3] = rb_r[1][col];
    win_next_s[0][3] = rb_r[2][col];
  end

  // Advance window and push the column slice down through the row buffers.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_r[r][c] <= win_next_s[r][c];
        end
      end
      rb_r[0][col] <= pix;
      rb_r[1][col] <= rb_r[0][col];
      rb_r[2][col] <= rb_r[1][col];
    end
  end

  // Flatten the next window into the k = 4*kr + kc word layout.
  always_comb begin
    win_flat = '0;
    for (int kr = 0; kr < 4; kr++) begin
      for (int kc = 0; kc < 4; kc++) begin
        win_flat[(4*kr+kc)*DATA_WIDTH +: DATA_WIDTH] = win_next_s[kr][kc];
      end
    end
  end

endmodule

// File: rtl/conv2d_4x4_s2_layer.sv
// conv2d_4x4_s2_layer: streaming 4x4 stride-2 valid convolution, one pixel per
// accepted beat, single registered output stage.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of the pixel/result handshake (see _if)
//   w_flat   : 16 kernel words, k = 4*kr + kc; static during a frame
//   bias     : signed bias in the pixel Q format
// sat_shift is sized from figan_pkg, so DATA_WIDTH/FRAC_BITS overrides must
// match the package defaults.
module conv2d_4x4_s2_layer #(
  parameter int IN_WIDTH   = 23,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  conv2d_4x4_s2_layer_if.slave     bus,
  input  logic [16*DATA_WIDTH-1:0] w_flat,
  input  logic [DATA_WIDTH-1:0]    bias
);

  import figan_pkg::*;

  localparam int COL_W     = $clog2(IN_WIDTH);
  localparam int OUT_WIDTH = (IN_WIDTH - 4) / 2 + 1;
  localparam int LAST_POS  = 3 + 2 * (OUT_WIDTH - 1);

  logic [COL_W-1:0]             row_r;
  logic [COL_W-1:0]             col_r;
  logic                         accept_s;
  logic                         emit_s;
  logic                         last_s;
  logic [16*DATA_WIDTH-1:0]     win_flat_s;
  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic signed [ACC_WIDTH-1:0]  acc_s;
  logic                         valid_out_r;
  logic                         last_out_r;
  logic [DATA_WIDTH-1:0]        data_out_r;

  // Single output register: a free slot or a draining one can take a pixel.
  assign bus.ready_out = !valid_out_r || bus.ready_in;
  assign accept_s      = bus.valid_in && bus.ready_out;
  assign bus.valid_out = valid_out_r;
  assign bus.data_out  = data_out_r;
  assign bus.last_out  = last_out_r;

  // (row-3) and (col-3) even means row and col are odd.
  assign emit_s = accept_s && (row_r >= COL_W'(3)) && (col_r >= COL_W'(3)) &&
                  row_r[0] && col_r[0];
  assign last_s = (row_r == COL_W'(LAST_POS)) && (col_r == COL_W'(LAST_POS));

  line_buffer_rows #(
    .IN_WIDTH   (IN_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_line_buffer_rows (
    .clk      (clk),
    .en       (accept_s),
    .col      (col_r),
    .pix      (bus.data_in),
    .win_flat (win_flat_s)
  );

  // 16-tap MAC over the window that already contains the incoming pixel.
  always_comb begin
    prod_s = '0;
    acc_s  = {{(ACC_WIDTH-DATA_WIDTH-FRAC_BITS){bias[DATA_WIDTH-1]}}, bias,
              {FRAC_BITS{1'b0}}};
    for (int k = 0; k < 16; k++) begin
      prod_s = $signed(win_flat_s[k*DATA_WIDTH +: DATA_WIDTH]) *
               $signed(w_flat[k*DATA_WIDTH +: DATA_WIDTH]);
      acc_s  = acc_s + {{(ACC_WIDTH-2*DATA_WIDTH){prod_s[2*DATA_WIDTH-1]}}, prod_s};
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_r <= '0;
      col_r <= '0;
    end else if (accept_s) begin
      if (col_r == COL_W'(IN_WIDTH - 1)) begin
        col_r <= '0;
        if (row_r == COL_W'(IN_WIDTH - 1)) begin
          row_r <= '0;
        end else begin
          row_r <= row_r + COL_W'(1);
        end
      end else begin
        col_r <= col_r + COL_W'(1);
      end
    end
  end

  // Output register: load on emit (overwrite allowed while draining), else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out_r <= 1'b0;
      data_out_r  <= '0;
      last_out_r  <= 1'b0;
    end else if (emit_s) begin
      valid_out_r <= 1'b1;
      data_out_r  <= sat_shift(acc_s);
      last_out_r  <= last_s;
    end else if (bus.ready_in) begin
      valid_out_r <= 1'b0;
      last_out_r  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv2d_4x4_s2_layer.sv
// tb_conv2d_4x4_s2_layer: randomized self-checking bench for conv2d_4x4_s2_layer.
// Expected results come from a direct 2-D convolution over a stored frame.
module tb_conv2d_4x4_s2_layer;

  localparam int IW = 23;
  localparam int DW = 16;
  localparam int OW = (IW - 4) / 2 + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [16*DW-1:0] w_flat;
  logic [DW-1:0]    bias;

  conv2d_4x4_s2_layer_if #(.DATA_WIDTH(DW)) bus ();

  conv2d_4x4_s2_layer #(
    .IN_WIDTH   (IW),
    .DATA_WIDTH (DW),
    .FRAC_BITS  (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .w_flat (w_flat),
    .bias   (bias)
  );

  always #5 clk = ~clk;

  int            err_cnt = 0;
  int            chk_cnt = 0;
  logic [DW-1:0] w_arr [16];
  logic [DW-1:0] px_q [$];
  logic [DW-1:0] exp_q [$];
  logic          exp_last_q [$];
  int            img [IW][IW];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
    end
  endtask

  task automatic load_weights();
    for (int k = 0; k < 16; k++) w_flat[k*DW +: DW] = w_arr[k];
  endtask

  function automatic logic [DW-1:0] gen_pix(input int mode, input int r, input int c);
    int v;
    case (mode)
      0:       v = 256;
      1:       v = (4 * r + c) * 256;
      2:       v = 32767;
      3:       v = int'($urandom_range(4095)) - 2048;
      default: v = 0;
    endcase
    return DW'(v);
  endfunction

  // Append one frame of pixels and its convolution results to the queues.
  task automatic add_frame(input int mode);
    logic [DW-1:0] p;
    longint acc;
    for (int r = 0; r < IW; r++) begin
      for (int c = 0; c < IW; c++) begin
        p = gen_pix(mode, r, c);
        img[r][c] = int'($signed(p));
        px_q.push_back(p);
      end
    end
    for (int i = 0; i < OW; i++) begin
      for (int j = 0; j < OW; j++) begin
        acc = longint'($signed(bias)) * 256;
        for (int kr = 0; kr < 4; kr++)
          for (int kc = 0; kc < 4; kc++)
            acc += longint'(img[2*i+kr][2*j+kc]) * longint'($signed(w_arr[4*kr+kc]));
        acc = acc >>> 8;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        exp_q.push_back(DW'(acc));
        exp_last_q.push_back((i == OW - 1) && (j == OW - 1));
      end
    end
  endtask

  // Stream queued pixels and score results; optional stall and early abort.
  task automatic run_stream(input int vduty, input int rduty, input int stall,
                            input int abort_at, input string name);
    int idx = 0;
    int got = 0;
    int cycles = 0;
    int stall_left = stall;
    int n_exp = exp_q.size();
    int budget = px_q.size() * 8 + 500;
    bit stalling;
    bit abort = 1'b0;
    while ((idx < px_q.size() || exp_q.size() > 0) && cycles < budget && !abort) begin
      @(negedge clk);
      cycles++;
      stalling = (stall_left > 0) && (bus.valid_out === 1'b1);
      bus.valid_in = (idx < px_q.size()) && (stalling || ($urandom_range(99) < vduty));
      bus.data_in  = (idx < px_q.size()) ? px_q[idx] : '0;
      bus.ready_in = stalling ? 1'b0 : ($urandom_range(99) < rduty);
      #1;
      if (stalling) begin
        stall_left--;
        check_val({name, " stall ready_out"}, 32'(bus.ready_out), 32'd0);
        if (exp_q.size() > 0) check_val({name, " stall data"}, 32'(bus.data_out), 32'(exp_q[0]));
      end
      if (bus.valid_out && bus.ready_in) begin
        if (exp_q.size() == 0) begin
          check_val({name, " output count"}, 32'(got + 1), 32'(n_exp));
        end else begin
          check_val($sformatf("%s data[%0d]", name, got), 32'(bus.data_out), 32'(exp_q[0]));
          check_val($sformatf("%s last[%0d]", name, got), 32'(bus.last_out), 32'(exp_last_q[0]));
          void'(exp_q.pop_front());
          void'(exp_last_q.pop_front());
        end
        got++;
      end
      if (bus.valid_in && bus.ready_out) begin
        idx++;
        if (abort_at > 0 && idx == abort_at) abort = 1'b1;
      end
    end
    if (abort_at == 0) begin
      check_val({name, " pixels consumed"}, 32'(idx), 32'(px_q.size()));
      check_val({name, " output count"}, 32'(got), 32'(n_exp));
    end
    px_q.delete();
    exp_q.delete();
    exp_last_q.delete();
  endtask

  initial begin
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.ready_in = 1'b0;
    bias         = '0;
    for (int k = 0; k < 16; k++) w_arr[k] = '0;
    load_weights();
    repeat (3) @(negedge clk);
    check_val("reset valid_out", 32'(bus.valid_out), 32'd0);
    check_val("reset data_out", 32'(bus.data_out), 32'd0);
    check_val("reset last_out", 32'(bus.last_out), 32'd0);
    check_val("reset ready_out", 32'(bus.ready_out), 32'd1);
    rst = 1'b0;

    // All-ones frame: 16 taps of 1.0 * 1.0 = 16.0
    for (int k = 0; k < 16; k++) w_arr[k] = 16'h0100;
    bias = 16'h0000;
    load_weights();
    add_frame(0);
    run_stream(100, 100, 0, 0, "ones");

    // Identity on the newest tap plus 0.5 bias, with a 5-cycle backpressure stall
    for (int k = 0; k < 16; k++) w_arr[k] = 16'h0000;
    w_arr[15] = 16'h0100;
    bias = 16'h0080;
    load_weights();
    add_frame(1);
    run_stream(100, 100, 5, 0, "ident");

    // Positive then negative saturation
    for (int k = 0; k < 16; k++) w_arr[k] = 16'h7FFF;
    bias = 16'h0000;
    load_weights();
    add_frame(2);
    run_stream(100, 100, 0, 0, "sat_pos");
    for (int k = 0; k < 16; k++) w_arr[k] = 16'h8000;
    load_weights();
    add_frame(2);
    run_stream(100, 100, 0, 0, "sat_neg");

    // Reset after 200 pixels, then a clean all-ones frame
    for (int k = 0; k < 16; k++) w_arr[k] = 16'h0100;
    bias = 16'h0000;
    load_weights();
    add_frame(0);
    run_stream(100, 100, 0, 200, "pre_rst");
    @(negedge clk);
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    #1;
    check_val("rst valid_out", 32'(bus.valid_out), 32'd0);
    @(negedge clk);
    check_val("rst held valid_out", 32'(bus.valid_out), 32'd0);
    rst = 1'b0;
    add_frame(0);
    run_stream(100, 100, 0, 0, "post_rst");

    // Random kernel, bias and pixels over 3 frames with 50% gaps on both sides
    for (int k = 0; k < 16; k++) w_arr[k] = DW'(int'($urandom_range(1023)) - 512);
    bias = DW'(int'($urandom_range(4095)) - 2048);
    load_weights();
    add_frame(3);
    add_frame(3);
    add_frame(3);
    run_stream(50, 50, 0, 0, "rand");

    @(negedge clk);
    bus.valid_in = 1'b0;
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
